// File: rtl/btn_pkg.sv
// Shared constants for the button debounce/pulse slice: default sizing and
// the channel-to-function mapping used by the counter controller.
package btn_pkg;

    localparam int DEF_N_BTN      = 3;
    localparam int DEF_TICK_DIV   = 100_000;
    localparam int DEF_STABLE_CNT = 8;

    localparam int BTN_ENABLE = 0;
    localparam int BTN_CLEAR  = 1;
    localparam int BTN_MODE   = 2;

    // Width needed to hold a count from 0 up to and including max_val.
    function automatic int count_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, tick-gated stability counter,
// debounced level, and a registered one-cycle pulse on each 0->1 level edge.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int STABLE_CNT = DEF_STABLE_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic level,
    output logic pulse
);

    localparam int CW = count_width(STABLE_CNT);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CNT - 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] stab_cnt;
    logic [CW-1:0] stab_cnt_nxt;
    logic          level_nxt;
    logic          level_d;

    // Bring the raw asynchronous button into the clock domain before use.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
        end
    end

    // On a tick, count disagreeing samples; flip the level on the last one so the counter never passes STABLE_CNT.
    always_comb begin
        stab_cnt_nxt = stab_cnt;
        level_nxt    = level;
        if (tick) begin
            if (sync_b != level) begin
                if (stab_cnt == LAST) begin
                    level_nxt    = ~level;
                    stab_cnt_nxt = '0;
                end else begin
                    stab_cnt_nxt = stab_cnt + CW'(1);
                end
            end else begin
                stab_cnt_nxt = '0;
            end
        end
    end

    // Hold the debounced level and its stability count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stab_cnt <= '0;
            level    <= 1'b0;
        end else begin
            stab_cnt <= stab_cnt_nxt;
            level    <= level_nxt;
        end
    end

    // Pulse for one cycle right after the level rises; falling edges are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_d <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_d <= level;
            pulse   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/btn_debounce_pulse.sv
// Multi-channel button debouncer with press pulses. A single prescaler sets
// the sample rate for every channel so simultaneous presses stay aligned.
// Channel BTN_ENABLE drives the counter enable, BTN_CLEAR its clear and
// BTN_MODE its mode. TICK_DIV must be at least 2 and STABLE_CNT at least 1.
module btn_debounce_pulse
    import btn_pkg::*;
#(
    parameter int N_BTN      = DEF_N_BTN,
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int STABLE_CNT = DEF_STABLE_CNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_pulse
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] ps_cnt;
    logic          tick;

    assign tick = (ps_cnt == PS_LAST);

    // Free-running prescaler 0..TICK_DIV-1; the tick marks its last count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PW'(1);
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .STABLE_CNT (STABLE_CNT)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .btn   (i_btn[g]),
            .level (o_level[g]),
            .pulse (o_pulse[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with TICK_DIV=10, STABLE_CNT=4.
module tb_btn_debounce_pulse;

    localparam int TD = 10;
    localparam int SC = 4;
    localparam int NB = 3;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic [NB-1:0] i_btn = '0;
    logic [NB-1:0] o_level;
    logic [NB-1:0] o_pulse;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            high_cnt [NB];
    int            first_hi [NB];
    int            lvl_hi   [NB];
    logic [NB-1:0] first_vec;
    int            bounce_pulses;
    int            bounce_lvl;
    bit            found;

    btn_debounce_pulse #(
        .N_BTN      (NB),
        .TICK_DIV   (TD),
        .STABLE_CNT (SC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (i_btn),
        .o_level (o_level),
        .o_pulse (o_pulse)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkRange(input string tag, input int val, input int lo, input int hi);
        n_checks++;
        assert (val >= lo && val <= hi) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d required %0d..%0d", tag, val, lo, hi);
        end
    endtask

    task automatic applyStimulus(input logic [NB-1:0] btn);
        i_btn = btn;
    endtask

    task automatic watch(input int n);
        for (int ch = 0; ch < NB; ch++) begin
            high_cnt[ch] = 0;
            first_hi[ch] = 0;
            lvl_hi[ch]   = 0;
        end
        first_vec = '0;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_pulse != '0 && first_vec == '0) first_vec = o_pulse;
            for (int ch = 0; ch < NB; ch++) begin
                if (o_pulse[ch] === 1'b1) begin
                    high_cnt[ch]++;
                    if (first_hi[ch] == 0) first_hi[ch] = c;
                end
                if (o_level[ch] === 1'b1) lvl_hi[ch]++;
            end
        end
    endtask

    initial begin
        // Reset held with all buttons pressed: outputs stay low.
        rst = 1'b0;
        applyStimulus(3'b111);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("reset_level", 32'(o_level), 32'd0);
            checkOutput("reset_pulse", 32'(o_pulse), 32'd0);
        end
        rst = 1'b1;
        watch(50);
        for (int ch = 0; ch < NB; ch++) begin
            checkOutput($sformatf("post_reset_pulse_cycle_ch%0d", ch), 32'(first_hi[ch]), 32'd41);
            checkOutput($sformatf("post_reset_pulse_width_ch%0d", ch), 32'(high_cnt[ch]), 32'd1);
        end
        checkOutput("post_reset_pulse_vec", 32'(first_vec), 32'd7);
        checkOutput("post_reset_level", 32'(o_level), 32'd7);

        // Release everything: levels fall, no pulses.
        applyStimulus(3'b000);
        watch(60);
        checkOutput("release_all_pulses", 32'(high_cnt[0] + high_cnt[1] + high_cnt[2]), 32'd0);
        checkOutput("release_all_level", 32'(o_level), 32'd0);

        // Clean press on channel 0.
        applyStimulus(3'b001);
        watch(100);
        checkRange("press_latency_ch0", first_hi[0], 34, 43);
        checkOutput("press_pulse_cycles_ch0", 32'(high_cnt[0]), 32'd1);
        checkOutput("press_other_pulses", 32'(high_cnt[1] + high_cnt[2]), 32'd0);
        checkOutput("press_level", 32'(o_level), 32'd1);

        // Release channel 0 for 50 cycles, then press again.
        applyStimulus(3'b000);
        watch(50);
        checkOutput("release_pulse_ch0", 32'(high_cnt[0]), 32'd0);
        checkOutput("release_level", 32'(o_level), 32'd0);
        applyStimulus(3'b001);
        watch(60);
        checkRange("repress_latency_ch0", first_hi[0], 34, 43);
        checkOutput("repress_pulse_cycles_ch0", 32'(high_cnt[0]), 32'd1);
        checkOutput("repress_level", 32'(o_level), 32'd1);
        applyStimulus(3'b000);
        watch(60);
        checkOutput("repress_release_level", 32'(o_level), 32'd0);

        // Bounce on channel 1: toggle every 7 cycles for 60 cycles.
        bounce_pulses = 0;
        bounce_lvl    = 0;
        for (int k = 0; k < 60; k++) begin
            applyStimulus({1'b0, ((k / 7) % 2 == 0), 1'b0});
            @(posedge clk);
            @(negedge clk);
            if (o_pulse != '0) bounce_pulses++;
            if (o_level != '0) bounce_lvl++;
        end
        checkOutput("bounce_pulses", 32'(bounce_pulses), 32'd0);
        checkOutput("bounce_level_cycles", 32'(bounce_lvl), 32'd0);
        applyStimulus(3'b010);
        watch(60);
        checkOutput("bounce_settle_pulse_ch1", 32'(high_cnt[1]), 32'd1);
        checkOutput("bounce_settle_level", 32'(o_level), 32'd2);
        applyStimulus(3'b000);
        watch(60);
        checkOutput("bounce_release_level", 32'(o_level), 32'd0);

        // Glitch on channel 2: 25 cycles high is too short.
        applyStimulus(3'b100);
        watch(25);
        checkOutput("glitch_level_ch2", 32'(lvl_hi[2]), 32'd0);
        checkOutput("glitch_pulse_ch2", 32'(high_cnt[2]), 32'd0);
        applyStimulus(3'b000);
        watch(50);
        checkOutput("glitch_after_level_ch2", 32'(lvl_hi[2]), 32'd0);
        checkOutput("glitch_after_pulse_ch2", 32'(high_cnt[2]), 32'd0);

        // Simultaneous press of all channels.
        applyStimulus(3'b111);
        watch(60);
        checkOutput("simul_pulse_vec", 32'(first_vec), 32'd7);
        for (int ch = 0; ch < NB; ch++)
            checkOutput($sformatf("simul_pulse_cycles_ch%0d", ch), 32'(high_cnt[ch]), 32'd1);
        applyStimulus(3'b000);
        watch(60);
        checkOutput("simul_release_level", 32'(o_level), 32'd0);

        // Reset asserted while a pulse is high clears it at once.
        applyStimulus(3'b001);
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_pulse[0] === 1'b1) found = 1'b1;
        end
        checkOutput("pulse_wait_found", 32'(found), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("reset_during_pulse_pulse", 32'(o_pulse), 32'd0);
        checkOutput("reset_during_pulse_level", 32'(o_level), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        watch(50);
        checkOutput("held_after_reset_cycle", 32'(first_hi[0]), 32'd41);
        checkOutput("held_after_reset_cycles", 32'(high_cnt[0]), 32'd1);
        applyStimulus(3'b000);
        watch(60);

        // Reset mid-debounce discards the partial stability count.
        applyStimulus(3'b001);
        repeat (25) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        watch(50);
        checkOutput("mid_debounce_reset_cycle", 32'(first_hi[0]), 32'd41);
        checkOutput("mid_debounce_reset_cycles", 32'(high_cnt[0]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
